// File: rtl/vector_reduce_unit.sv
// vector_reduce_unit
// Folds the active elements of the ALU result vector into one scalar:
// signed sum, signed max, signed min, or a count of non-zero elements.
// One element is consumed per clock under a start/busy/done handshake.
// Optional feature: define VREDUCE_INDEX_EN to report the index of the
// winning max/min element on res_idx. Without it, res_idx is tied to 0.

module vector_reduce_unit #(
    parameter int BITS     = 8,
    parameter int N        = 64,
    parameter int ACC_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N*BITS-1:0]     vec,
    input  logic [7:0]            vec_len,
    input  logic [1:0]            op,
    input  logic                  start,
    input  logic                  clear,
    output logic                  busy,
    output logic                  done,
    output logic [ACC_BITS-1:0]   result,
    output logic [7:0]            res_idx
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [1:0]                  op_q;
    logic [7:0]                  cnt;
    logic [7:0]                  idx;
    logic signed [ACC_BITS-1:0]  acc;
    logic signed [ACC_BITS-1:0]  acc_next;
    logic [BITS-1:0]             elems [N];
    logic [BITS-1:0]             elem;
    logic signed [ACC_BITS-1:0]  elem_ext;
    logic [ACC_BITS-1:0]         nz_inc;
    logic [7:0]                  len_clamped;
    logic                        accept;
    logic                        first;
    logic                        last;
    logic                        take_elem;

    // Unpack the flat vector into elements so the current one can be indexed
    always_comb begin
        for (int i = 0; i < N; i++) begin
            elems[i] = vec[i*BITS +: BITS];
        end
    end

    assign elem        = elems[idx[IDX_W-1:0]];
    assign elem_ext    = {{(ACC_BITS-BITS){elem[BITS-1]}}, elem};
    assign nz_inc      = {{(ACC_BITS-1){1'b0}}, (elem != '0)};
    assign len_clamped = (vec_len > 8'(N)) ? 8'(N) : vec_len;
    assign accept      = (state != RUN) && start && !clear;
    assign first       = (idx == 8'd0);
    assign last        = (idx == cnt - 8'd1);

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; clear overrides everything, DONE accepts a new start
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_next = (len_clamped == 8'd0) ? DONE : RUN;
                    end else begin
                        state_next = IDLE;
                    end
                end
                RUN: begin
                    if (last) begin
                        state_next = DONE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Fold the current element into the accumulator; the first element restarts it
    always_comb begin
        acc_next  = acc;
        take_elem = 1'b0;
        case (op_q)
            2'b00: acc_next = (first ? '0 : acc) + elem_ext;
            2'b01: begin
                take_elem = first || (elem_ext > acc);
                if (take_elem) acc_next = elem_ext;
            end
            2'b10: begin
                take_elem = first || (elem_ext < acc);
                if (take_elem) acc_next = elem_ext;
            end
            default: acc_next = (first ? '0 : acc) + nz_inc;
        endcase
    end

    // Datapath: latch the job on accept, step through elements, publish on the last one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= '0;
            cnt    <= '0;
            idx    <= '0;
            acc    <= '0;
            result <= '0;
        end else if (clear) begin
            cnt    <= '0;
            idx    <= '0;
            acc    <= '0;
            result <= '0;
        end else if (accept) begin
            op_q <= op;
            cnt  <= len_clamped;
            idx  <= '0;
            acc  <= '0;
            if (len_clamped == 8'd0) begin
                result <= '0;
            end
        end else if (state == RUN) begin
            acc <= acc_next;
            idx <= idx + 8'd1;
            if (last) begin
                result <= acc_next;
            end
        end
    end

`ifdef VREDUCE_INDEX_EN
    logic [7:0] best_idx;
    logic [7:0] best_next;
    logic [7:0] res_idx_q;

    assign best_next = take_elem ? idx : best_idx;
    assign res_idx   = res_idx_q;

    // Track the earliest winning index for max/min and publish it with the result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_idx  <= '0;
            res_idx_q <= '0;
        end else if (clear) begin
            best_idx  <= '0;
            res_idx_q <= '0;
        end else if (accept) begin
            best_idx <= '0;
            if (len_clamped == 8'd0) begin
                res_idx_q <= '0;
            end
        end else if (state == RUN) begin
            best_idx <= best_next;
            if (last) begin
                res_idx_q <= (op_q == 2'b01 || op_q == 2'b10) ? best_next : 8'd0;
            end
        end
    end
`else
    assign res_idx = '0;
`endif

endmodule

// File: tb/tb_vector_reduce_unit.sv
// Directed testbench for vector_reduce_unit (BITS=8, N=64, ACC_BITS=16).
// Expected values are hand-computed per vector.

module tb_vector_reduce_unit;

    localparam int BITS     = 8;
    localparam int N        = 64;
    localparam int ACC_BITS = 16;

    logic                 clk;
    logic                 rst;
    logic [N*BITS-1:0]    vec;
    logic [7:0]           vec_len;
    logic [1:0]           op;
    logic                 start;
    logic                 clear;
    logic                 busy;
    logic                 done;
    logic [ACC_BITS-1:0]  result;
    logic [7:0]           res_idx;

    int total;
    int bad;

    vector_reduce_unit #(
        .BITS    (BITS),
        .N       (N),
        .ACC_BITS(ACC_BITS)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .vec    (vec),
        .vec_len(vec_len),
        .op     (op),
        .start  (start),
        .clear  (clear),
        .busy   (busy),
        .done   (done),
        .result (result),
        .res_idx(res_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_elem(input int i, input logic [7:0] v);
        vec[i*BITS +: BITS] = v;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle start and wait (bounded) for done; reports latency in cycles after the sampling edge
    task automatic applyStimulus(input logic [7:0] len, input logic [1:0] o,
                                 output int busy_cnt, output int lat);
        vec_len = len;
        op      = o;
        start   = 1'b1;
        next_cycle();
        start    = 1'b0;
        lat      = 1;
        busy_cnt = 0;
        while (!done && lat < 400) begin
            if (busy) busy_cnt++;
            next_cycle();
            lat++;
        end
        if (!done) checkOutput("done_timeout", {31'b0, done}, 32'd1);
    endtask

    logic [7:0] exp_idx_max;
    logic [7:0] exp_idx_min;

    initial begin
        int bc;
        int lat;
        int pulses;
        logic [8:0] busy_pat;
        logic [8:0] done_pat;
        logic [15:0] res_b2b;

        total   = 0;
        bad     = 0;
        vec     = '0;
        vec_len = '0;
        op      = '0;
        start   = 1'b0;
        clear   = 1'b0;
`ifdef VREDUCE_INDEX_EN
        exp_idx_max = 8'd1;
        exp_idx_min = 8'd3;
`else
        exp_idx_max = 8'd0;
        exp_idx_min = 8'd0;
`endif

        // Reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        next_cycle();
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_result", {16'b0, result}, 32'd0);
        checkOutput("rst_res_idx", {24'b0, res_idx}, 32'd0);

        // Sum {5,-3,127,-128} = 1
        set_elem(0, 8'd5); set_elem(1, 8'hFD); set_elem(2, 8'd127); set_elem(3, 8'h80);
        applyStimulus(8'd4, 2'b00, bc, lat);
        checkOutput("sum_latency", lat, 32'd5);
        checkOutput("sum_busy_cycles", bc, 32'd4);
        checkOutput("sum_result", {16'b0, result}, 32'h0001);
        checkOutput("sum_res_idx", {24'b0, res_idx}, 32'd0);
        next_cycle();
        checkOutput("sum_done_pulse", {31'b0, done}, 32'd0);
        checkOutput("sum_result_hold", {16'b0, result}, 32'h0001);

        // Max / min over {-2,7,7,-9,3}
        vec = '0;
        set_elem(0, 8'hFE); set_elem(1, 8'd7); set_elem(2, 8'd7); set_elem(3, 8'hF7); set_elem(4, 8'd3);
        applyStimulus(8'd5, 2'b01, bc, lat);
        checkOutput("max_result", {16'b0, result}, 32'h0007);
        checkOutput("max_res_idx", {24'b0, res_idx}, {24'b0, exp_idx_max});
        next_cycle();
        applyStimulus(8'd5, 2'b10, bc, lat);
        checkOutput("min_result", {16'b0, result}, 32'hFFF7);
        checkOutput("min_res_idx", {24'b0, res_idx}, {24'b0, exp_idx_min});
        checkOutput("min_latency", lat, 32'd6);
        next_cycle();

        // Zero length: done next cycle, result cleared
        applyStimulus(8'd0, 2'b00, bc, lat);
        checkOutput("len0_latency", lat, 32'd1);
        checkOutput("len0_busy", bc, 32'd0);
        checkOutput("len0_result", {16'b0, result}, 32'd0);
        next_cycle();

        // Over-long length clamps to N; every element is -128 -> -8192
        for (int i = 0; i < N; i++) set_elem(i, 8'h80);
        applyStimulus(8'd200, 2'b00, bc, lat);
        checkOutput("clamp_busy_cycles", bc, 32'd64);
        checkOutput("clamp_latency", lat, 32'd65);
        checkOutput("clamp_sum", {16'b0, result}, 32'hE000);
        next_cycle();

        // Count on all-zero vector, then on mixed vector {0,3,0,-1,5}
        vec = '0;
        applyStimulus(8'd10, 2'b11, bc, lat);
        checkOutput("count_zero", {16'b0, result}, 32'd0);
        next_cycle();
        set_elem(1, 8'd3); set_elem(3, 8'hFF); set_elem(4, 8'd5);
        applyStimulus(8'd5, 2'b11, bc, lat);
        checkOutput("count_mixed", {16'b0, result}, 32'd3);
        checkOutput("count_res_idx", {24'b0, res_idx}, 32'd0);
        next_cycle();

        // Abort with clear in RUN cycle 3 of a len=10 sum
        for (int i = 0; i < 10; i++) set_elem(i, 8'(i + 1));
        vec_len = 8'd10;
        op      = 2'b00;
        start   = 1'b1;
        next_cycle();
        start = 1'b0;
        next_cycle();
        next_cycle();
        clear = 1'b1;
        next_cycle();
        clear = 1'b0;
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        checkOutput("abort_done", {31'b0, done}, 32'd0);
        checkOutput("abort_result", {16'b0, result}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) pulses++;
            next_cycle();
        end
        checkOutput("abort_no_activity", pulses, 32'd0);

        // Start and clear together: start dropped
        start = 1'b1;
        clear = 1'b1;
        next_cycle();
        start = 1'b0;
        clear = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (done || busy) pulses++;
            next_cycle();
        end
        checkOutput("start_clear_dropped", pulses, 32'd0);

        // Back-to-back: start held high through done, sum {1,2,3}
        vec_len = 8'd3;
        op      = 2'b00;
        start   = 1'b1;
        next_cycle();
        busy_pat = '0;
        done_pat = '0;
        res_b2b  = '0;
        for (int i = 1; i <= 9; i++) begin
            busy_pat[i-1] = busy;
            done_pat[i-1] = done;
            if (i == 8) res_b2b = result;
            if (i == 5) start = 1'b0;
            next_cycle();
        end
        checkOutput("b2b_busy_pattern", {23'b0, busy_pat}, 32'h077);
        checkOutput("b2b_done_pattern", {23'b0, done_pat}, 32'h088);
        checkOutput("b2b_result", {16'b0, res_b2b}, 32'd6);

        // Start pulsed during RUN is ignored; sum {1..5} = 15
        vec_len = 8'd5;
        start   = 1'b1;
        next_cycle();
        start = 1'b0;
        next_cycle();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        lat = 3;
        while (!done && lat < 400) begin
            next_cycle();
            lat++;
        end
        checkOutput("run_start_ignored_latency", lat, 32'd6);
        checkOutput("run_start_ignored_result", {16'b0, result}, 32'd15);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            if (busy || done) pulses++;
        end
        checkOutput("run_start_no_rerun", pulses, 32'd0);

        // Asynchronous reset in the middle of a run
        vec_len = 8'd10;
        start   = 1'b1;
        next_cycle();
        start = 1'b0;
        next_cycle();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrun_rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("midrun_rst_result", {16'b0, result}, 32'd0);
        next_cycle();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) pulses++;
            next_cycle();
        end
        checkOutput("midrun_rst_no_done", pulses, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
